// File: rtl/usb_data_transmission.sv
`default_nettype none
// ============================================================================
// Module   : usb_data_transmission
// Brief    : USB full-speed transmitter: SYNC + LSB-first data + EOP framing,
//            bit stuffing and NRZI encoding onto the D+/D- pair.
// Revision : 1.0
// ============================================================================
module usb_data_transmission #(
    parameter int         CLK_PER_BIT  = 10,
    parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
    input  logic       useClk,
    input  logic       NotReset,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       busy,
    output logic       outputEnable,
    output logic       serialData,
    output logic       NotserialData
);

    localparam int                 c_DIV_W    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [c_DIV_W-1:0] c_LAST_DIV = c_DIV_W'(CLK_PER_BIT - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_EOP_SE0 = 3'd3,
        S_EOP_J   = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_bitCnt;
    logic [2:0]         r_onesCnt;
    logic [6:0]         r_shift;
    logic               r_lineJ;
    logic               r_txReady;

    state_t             w_stateNext;
    logic [c_DIV_W-1:0] w_divNext;
    logic [2:0]         w_bitCntNext;
    logic [2:0]         w_onesNext;
    logic [6:0]         w_shiftNext;
    logic               w_lineNext;
    logic               w_readyNext;
    logic               w_bitTick;
    logic               w_emit;
    logic               w_emitBit;
    logic               w_stuff;
    logic [2:0]         w_nextIdx;

    assign w_bitTick = (r_state != S_IDLE) && (r_div == c_LAST_DIV);
    assign w_nextIdx = r_bitCnt + 3'd1;

    always_ff @(posedge useClk or negedge NotReset) begin
        if (!NotReset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bitCnt  <= '0;
            r_onesCnt <= '0;
            r_shift   <= '0;
            r_lineJ   <= 1'b1;
            r_txReady <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_div     <= w_divNext;
            r_bitCnt  <= w_bitCntNext;
            r_onesCnt <= w_onesNext;
            r_shift   <= w_shiftNext;
            r_lineJ   <= w_lineNext;
            r_txReady <= w_readyNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_divNext    = (r_state == S_IDLE || w_bitTick) ? '0 : r_div + c_DIV_ONE;
        w_bitCntNext = r_bitCnt;
        w_onesNext   = r_onesCnt;
        w_shiftNext  = r_shift;
        w_lineNext   = r_lineJ;
        w_readyNext  = 1'b0;
        w_emit       = 1'b0;
        w_emitBit    = 1'b0;
        w_stuff      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (txValid) begin
                    w_stateNext  = S_SYNC;
                    w_bitCntNext = 3'd0;
                    w_emit       = 1'b1;
                    w_emitBit    = SYNC_PATTERN[0];
                end
            end
            S_SYNC, S_DATA: begin
                if (w_bitTick) begin
                    // A pending stuff bit takes priority; the byte position holds still
                    if (r_onesCnt == 3'd6) begin
                        w_stuff = 1'b1;
                    end else if (r_bitCnt != 3'd7) begin
                        w_bitCntNext = w_nextIdx;
                        w_emit       = 1'b1;
                        if (r_state == S_SYNC) begin
                            w_emitBit = SYNC_PATTERN[w_nextIdx];
                        end else begin
                            w_emitBit   = r_shift[0];
                            w_shiftNext = {1'b0, r_shift[6:1]};
                        end
                    end else if (txValid) begin
                        w_stateNext  = S_DATA;
                        w_bitCntNext = 3'd0;
                        w_shiftNext  = txData[7:1];
                        w_emit       = 1'b1;
                        w_emitBit    = txData[0];
                        w_readyNext  = 1'b1;
                    end else begin
                        w_stateNext  = S_EOP_SE0;
                        w_bitCntNext = 3'd0;
                        w_onesNext   = 3'd0;
                    end
                end
            end
            S_EOP_SE0: begin
                if (w_bitTick) begin
                    if (r_bitCnt == 3'd1) begin
                        w_stateNext  = S_EOP_J;
                        w_bitCntNext = 3'd0;
                        w_lineNext   = 1'b1;
                    end else begin
                        w_bitCntNext = w_nextIdx;
                    end
                end
            end
            S_EOP_J: begin
                if (w_bitTick) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_lineNext  = 1'b1;
            end
        endcase

        // NRZI: a zero (data or stuffed) toggles the line, a one holds it
        if (w_stuff || (w_emit && !w_emitBit)) begin
            w_lineNext = ~r_lineJ;
            w_onesNext = 3'd0;
        end else if (w_emit) begin
            w_onesNext = r_onesCnt + 3'd1;
        end
    end

    assign txReady       = r_txReady;
    assign busy          = (r_state != S_IDLE);
    assign outputEnable  = (r_state != S_IDLE);
    assign serialData    = (r_state == S_EOP_SE0) ? 1'b0 : r_lineJ;
    assign NotserialData = (r_state == S_EOP_SE0) ? 1'b0 : ~r_lineJ;

endmodule
`default_nettype wire

// File: tb/tb_usb_data_transmission.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_data_transmission
// Brief    : Bench for usb_data_transmission: packet-level line model and a
//            per-cycle compare of D+/D-, outputEnable, busy and txReady.
// Revision : 1.0
// ============================================================================
module tb_usb_data_transmission;

    localparam int         CLK_PER_BIT = 10;
    localparam logic [4:0] c_IDLE_REC  = 5'b10000;  // {D+, D-, oe, busy, ready}

    logic       useClk   = 1'b0;
    logic       NotReset = 1'b0;
    logic [7:0] txData   = 8'h00;
    logic       txValid  = 1'b0;
    logic       txReady;
    logic       busy;
    logic       outputEnable;
    logic       serialData;
    logic       NotserialData;

    usb_data_transmission #(
        .CLK_PER_BIT  (CLK_PER_BIT),
        .SYNC_PATTERN (8'h80)
    ) dut (
        .useClk        (useClk),
        .NotReset      (NotReset),
        .txData        (txData),
        .txValid       (txValid),
        .txReady       (txReady),
        .busy          (busy),
        .outputEnable  (outputEnable),
        .serialData    (serialData),
        .NotserialData (NotserialData)
    );

    always #5 useClk = ~useClk;

    int         errors   = 0;
    int         checks   = 0;
    int         cyc      = 0;
    int         oeCount  = 0;
    int         startC   = 0;
    int         byteIdx  = 0;
    logic [4:0] expQ[$];
    int         readyLog[$];
    logic [7:0] plan[$];
    int         planLen[$];
    logic [7:0] curBytes[$];
    string      symStr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Expected line symbols for the packet in curBytes, expanded to one record per clock
    task automatic buildModel();
        logic       lvl;
        int         ones;
        logic [1:0] syms[$];
        int         loads[$];
        logic [7:0] cur;
        logic       b;
        logic       isLoad;
        string      ch;
        lvl    = 1'b1;
        ones   = 0;
        symStr = "";
        for (int i = 0; i < 8 * (1 + curBytes.size()); i++) begin
            cur = (i < 8) ? 8'h80 : curBytes[i / 8 - 1];
            if (i >= 8 && i % 8 == 0) loads.push_back(syms.size());
            b = cur[i % 8];
            if (!b) begin
                lvl  = !lvl;
                ones = 0;
            end else begin
                ones++;
            end
            syms.push_back(lvl ? 2'b10 : 2'b01);
            if (ones == 6) begin
                lvl  = !lvl;
                ones = 0;
                syms.push_back(lvl ? 2'b10 : 2'b01);
            end
        end
        syms.push_back(2'b00);
        syms.push_back(2'b00);
        syms.push_back(2'b10);
        foreach (syms[s]) begin
            ch = (syms[s] == 2'b10) ? "J" : (syms[s] == 2'b01) ? "K" : "S";
            symStr = {symStr, ch};
            isLoad = 1'b0;
            foreach (loads[j]) if (loads[j] == s) isLoad = 1'b1;
            for (int k = 0; k < CLK_PER_BIT; k++)
                expQ.push_back({syms[s], 2'b11, (k == 0) && isLoad});
        end
    endtask

    task automatic loadNext();
        int n;
        n = planLen.pop_front();
        curBytes.delete();
        for (int i = 0; i < n; i++) curBytes.push_back(plan.pop_front());
        buildModel();
        startC  = cyc + 2;
        readyLog.delete();
        oeCount = 0;
        byteIdx = 0;
        txData  = curBytes[0];
        txValid = 1'b1;
    endtask

    task automatic serviceCycle();
        @(posedge useClk);
        #2;
        if (txReady === 1'b1 && byteIdx < curBytes.size()) begin
            byteIdx++;
            if (byteIdx < curBytes.size()) txData = curBytes[byteIdx];
            else txValid = 1'b0;
        end
    endtask

    // eopMode: 0 plain, 1 hold txValid from EOP into next packet, 2 pulse txValid in EOP
    task automatic runPlan(input int eopMode);
        int guard;
        guard = 0;
        while ((expQ.size() > 0 || planLen.size() > 0) && guard < 5000) begin
            if (expQ.size() == 0) begin
                expQ.push_back(c_IDLE_REC);
                loadNext();
            end
            serviceCycle();
            guard++;
            if (byteIdx == curBytes.size() && txValid == 1'b0) begin
                if (eopMode == 1 && expQ.size() == 15 && planLen.size() > 0) begin
                    expQ.push_back(c_IDLE_REC);
                    loadNext();
                end else if (eopMode == 2 && expQ.size() == 25) begin
                    txData  = 8'($urandom);
                    txValid = 1'b1;
                end
            end else if (eopMode == 2 && byteIdx == curBytes.size() && expQ.size() == 24) begin
                txValid = 1'b0;
            end
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL plan timeout: got %0d cycles, expected under 5000", guard);
        end
    endtask

    always @(negedge useClk) begin : compare
        logic [4:0] rec;
        rec = (expQ.size() > 0) ? expQ.pop_front() : c_IDLE_REC;
        cyc++;
        if (txReady === 1'b1) readyLog.push_back(cyc);
        if (outputEnable === 1'b1) oeCount++;
        check("line/oe/busy/ready", {serialData, NotserialData, outputEnable, busy, txReady}, rec);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int np;
        int len;
        NotReset = 1'b0;
        repeat (3) @(posedge useClk);
        #2;
        check("reset D+", serialData, 1);
        check("reset D-", NotserialData, 0);
        check("reset oe", outputEnable, 0);
        check("reset busy", busy, 0);
        check("reset ready", txReady, 0);
        NotReset = 1'b1;

        plan.push_back(8'hC3); planLen.push_back(1);
        runPlan(0);
        check("C3 symbols", symStr == "KJKJKJKKKKJKJKKKSSJ", 1);
        check("C3 oe cycles", oeCount, 190);
        check("C3 ready count", readyLog.size(), 1);
        check("C3 ready offset", (readyLog.size() > 0) ? readyLog[0] - startC : -1, 80);

        plan.push_back(8'hFF); planLen.push_back(1);
        runPlan(0);
        check("FF symbols", symStr == "KJKJKJKKKKKKKJJJJSSJ", 1);
        check("FF oe cycles", oeCount, 200);

        plan.push_back(8'h00); plan.push_back(8'h55); planLen.push_back(2);
        runPlan(0);
        check("00/55 ready count", readyLog.size(), 2);
        check("00/55 ready gap", (readyLog.size() > 1) ? readyLog[1] - readyLog[0] : -1, 80);

        plan.push_back(8'h7E); plan.push_back(8'hFC); planLen.push_back(2);
        runPlan(0);
        check("7E/FC ready count", readyLog.size(), 2);
        check("7E/FC ready gap", (readyLog.size() > 1) ? readyLog[1] - readyLog[0] : -1, 90);

        // Reset in the first data byte, just before a pending stuff bit
        plan.push_back(8'hFF); plan.push_back(8'h00); planLen.push_back(2);
        expQ.push_back(c_IDLE_REC);
        loadNext();
        repeat (121) serviceCycle();
        NotReset = 1'b0;
        txValid  = 1'b0;
        byteIdx  = curBytes.size();
        expQ.delete();
        #1;
        check("mid reset D+", serialData, 1);
        check("mid reset D-", NotserialData, 0);
        check("mid reset oe", outputEnable, 0);
        check("mid reset busy", busy, 0);
        repeat (3) serviceCycle();
        NotReset = 1'b1;
        plan.push_back(8'h3F); planLen.push_back(1);
        runPlan(0);

        plan.push_back(8'hA5); planLen.push_back(1);
        plan.push_back(8'hFF); plan.push_back(8'h01); planLen.push_back(2);
        runPlan(2);
        plan.push_back(8'h12); planLen.push_back(1);
        plan.push_back(8'hFE); plan.push_back(8'h7F); planLen.push_back(2);
        plan.push_back(8'h80); planLen.push_back(1);
        runPlan(1);

        for (int r = 0; r < 12; r++) begin
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 4);
                planLen.push_back(len);
                for (int q = 0; q < len; q++)
                    plan.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            end
            runPlan($urandom_range(0, 2));
        end

        repeat (3) serviceCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
